// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle for the fetch/prefetch unit: instruction-memory request and
// response channels, the redirect input from execute, and the decode-side
// instruction channel. The master modport is the fetch unit's view.
interface fetch_prefetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch/prefetch unit: issues sequential PCs to instruction memory, buffers
// in-order responses as {pc, instr} pairs and hands them to decode. A
// redirect flushes the buffer and discards responses still in flight.
// Credits (buffered + outstanding <= DEPTH) guarantee every in-flight
// response has a reserved buffer slot, so the FIFO never overflows.
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [ILEN-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [XLEN-1:0] pcq        [DEPTH];
    logic [PW-1:0]   pcq_rd;
    logic [PW-1:0]   pcq_wr;

    logic [CW:0]     credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_nonempty;
    logic            out_valid;

    assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    // Request only when out of reset, not redirecting, and a slot is reserved.
    assign req_valid     = rst && !bus.redirect_valid && (credit_used < DEPTH_W);
    assign req_fire      = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol violation and ignored.
    assign rsp_fire      = bus.imem_rsp_valid && (outstanding != '0);
    assign fifo_push     = rsp_fire && !bus.redirect_valid && (drop_cnt == '0);
    assign fifo_nonempty = (fifo_count != '0);
    assign out_valid     = fifo_nonempty && !bus.redirect_valid;
    assign fifo_pop      = out_valid && bus.if_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.if_valid       = out_valid;
    assign bus.if_instr       = fifo_nonempty ? fifo_instr[rd_ptr] : '0;
    assign bus.if_pc          = fifo_nonempty ? fifo_pc[rd_ptr]    : '0;

    // Next fetch address: redirect target, or advance one word per issued request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // In-flight request tracking; survives redirects so stale responses stay matched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            if (req_fire && !rsp_fire) begin
                outstanding <= outstanding + CW'(1);
            end else if (!req_fire && rsp_fire) begin
                outstanding <= outstanding - CW'(1);
            end
            if (req_fire) begin
                pcq_wr <= pcq_wr + PW'(1);
            end
            if (rsp_fire) begin
                pcq_rd <= pcq_rd + PW'(1);
            end
        end
    end

    // Addresses of in-flight requests, paired with responses as they return.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

    // Count of responses still to be discarded after the latest redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (bus.redirect_valid) begin
            drop_cnt <= outstanding - CW'(rsp_fire);
        end else if (rsp_fire && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Prefetch FIFO pointers and occupancy; a redirect empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (bus.redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // FIFO payload storage; only read while the entry is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc[wr_ptr]    <= pcq[pcq_rd];
            fifo_instr[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: an in-order variable-latency memory
// model feeds responses, and a scoreboard of expected {pc, instr} pairs is
// filled as responses return and drained as decode accepts instructions.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          ready;
    } mem_entry_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();
    fetch_prefetch_unit_if #(.XLEN(32), .ILEN(32)) bus_hi ();

    fetch_prefetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fetch_prefetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .bus(bus_hi)
    );

    mem_entry_t  mem_q[$];
    exp_entry_t  exp_q[$];
    logic [31:0] got_pc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          epoch;
    int          last_ready;
    int          lat_min;
    int          lat_max;
    int          req_count;
    int          drop_count;
    logic [31:0] exp_pc;
    logic        s_req_valid;
    logic        s_if_valid;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
    endtask

    task automatic clear_model();
        mem_q.delete();
        exp_q.delete();
        got_pc.delete();
        cyc        = 0;
        epoch      = 0;
        last_ready = -1;
        exp_pc     = 32'h0;
        req_count  = 0;
        drop_count = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        clear_model();
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs and memory response, then check outputs
    // and update the scoreboard for the handshakes at the coming edge.
    task automatic step(input logic redir, input logic [31:0] rpc,
                        input logic ifr, input logic reqr);
        mem_entry_t  head;
        mem_entry_t  ne;
        exp_entry_t  e;
        logic        exp_if_valid;
        logic        exp_req_valid;
        int          lat;
        @(negedge clk);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.if_ready       = ifr;
        bus.imem_req_ready = reqr;
        if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_q[0].data;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #2;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_if_valid  = bus.if_valid;

        exp_if_valid  = !redir && (exp_q.size() > 0);
        exp_req_valid = !redir && ((exp_q.size() + mem_q.size()) < DEPTH);

        checks++;
        if (bus.if_valid !== exp_if_valid) begin
            errors++;
            $display("[TB] FAIL if_valid cyc=%0d: got %b expected %b", cyc, bus.if_valid, exp_if_valid);
        end
        if (exp_q.size() == 0) begin
            checks++;
            if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin
                errors++;
                $display("[TB] FAIL empty_outputs cyc=%0d: got pc=%h instr=%h expected 0", cyc, bus.if_pc, bus.if_instr);
            end
        end
        if (exp_if_valid && ifr) begin
            e = exp_q.pop_front();
            got_pc.push_back(bus.if_pc);
            checks++;
            if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                errors++;
                $display("[TB] FAIL if_data cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                         cyc, bus.if_pc, bus.if_instr, e.pc, e.instr);
            end
        end

        if (bus.imem_rsp_valid) begin
            head = mem_q.pop_front();
            if (head.epoch == epoch && !redir) begin
                e.pc    = head.addr;
                e.instr = head.data;
                exp_q.push_back(e);
            end else begin
                drop_count++;
            end
        end

        checks++;
        if (bus.imem_req_valid !== exp_req_valid) begin
            errors++;
            $display("[TB] FAIL req_valid cyc=%0d: got %b expected %b", cyc, bus.imem_req_valid, exp_req_valid);
        end
        if (bus.imem_req_valid && reqr) begin
            req_count++;
            checks++;
            if (bus.imem_req_addr !== exp_pc) begin
                errors++;
                $display("[TB] FAIL req_addr cyc=%0d: got %h expected %h", cyc, bus.imem_req_addr, exp_pc);
            end
            lat = $urandom_range(lat_max, lat_min);
            ne.addr  = bus.imem_req_addr;
            ne.data  = instr_of(bus.imem_req_addr);
            ne.epoch = epoch;
            ne.ready = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
            last_ready = ne.ready;
            mem_q.push_back(ne);
            exp_pc = exp_pc + 32'd4;
        end

        if (redir) begin
            epoch++;
            exp_q.delete();
            exp_pc = rpc;
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        checks++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_if_valid: got %b expected 0", bus.if_valid);
        end
        checks++;
        if (bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_if_data: got instr=%h pc=%h expected 0", bus.if_instr, bus.if_pc);
        end
        checks++;
        if (bus_hi.imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hi_req_valid: got %b expected 0", bus_hi.imem_req_valid);
        end
        clear_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_pc_wrap();
        logic [31:0] exp_addr;
        exp_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 8; i++) begin
            #2;
            checks++;
            if (bus_hi.imem_req_valid !== (i < DEPTH)) begin
                errors++;
                $display("[TB] FAIL wrap_req_valid i=%0d: got %b expected %b", i, bus_hi.imem_req_valid, (i < DEPTH));
            end
            if (i < DEPTH) begin
                checks++;
                if (bus_hi.imem_req_addr !== exp_addr) begin
                    errors++;
                    $display("[TB] FAIL wrap_req_addr i=%0d: got %h expected %h", i, bus_hi.imem_req_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (i >= 2) begin
                checks++;
                if (s_if_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL seq_if_valid_steady i=%0d: got %b expected 1", i, s_if_valid);
                end
            end
        end
        checks++;
        if (got_pc.size() != 10) begin
            errors++;
            $display("[TB] FAIL seq_delivered: got %0d expected 10", got_pc.size());
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (req_count != DEPTH) begin
            errors++;
            $display("[TB] FAIL credit_req_count: got %0d expected %0d", req_count, DEPTH);
        end
        checks++;
        if (s_req_valid !== 1'b0 || s_if_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL credit_full_state: got req_valid=%b if_valid=%b expected 0/1", s_req_valid, s_if_valid);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h10 || req_count != DEPTH + 1) begin
            errors++;
            $display("[TB] FAIL credit_refill: got valid=%b addr=%h count=%0d expected 1/00000010/%0d",
                     s_req_valid, s_req_addr, req_count, DEPTH + 1);
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        lat_min = 5;
        lat_max = 5;
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        lat_min = 1;
        lat_max = 1;
        step(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (15) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (drop_count != 3) begin
            errors++;
            $display("[TB] FAIL flush_dropped: got %0d expected 3", drop_count);
        end
        checks++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104) begin
            errors++;
            $display("[TB] FAIL flush_first_pcs: got %0d entries expected 00000100,00000104 first", got_pc.size());
        end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        lat_min = 2;
        lat_max = 2;
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        checks++;
        if (s_if_valid !== 1'b0 || s_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collide_outputs: got if_valid=%b req_valid=%b expected 0/0", s_if_valid, s_req_valid);
        end
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (drop_count != 2) begin
            errors++;
            $display("[TB] FAIL collide_dropped: got %0d expected 2", drop_count);
        end
        checks++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h200) begin
            errors++;
            $display("[TB] FAIL collide_first_pc: got %0d entries expected 00000200 first", got_pc.size());
        end
    endtask

    task automatic test_back_to_back();
        int base;
        lat_min = 1;
        lat_max = 3;
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        base = got_pc.size();
        step(1'b1, 32'h300, 1'b1, 1'b1);
        step(1'b1, 32'h400, 1'b1, 1'b1);
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (got_pc.size() <= base || got_pc[base] !== 32'h400) begin
            errors++;
            $display("[TB] FAIL b2b_first_pc: got %0d new entries expected 00000400 first", got_pc.size() - base);
        end
    endtask

    task automatic test_random();
        logic        redir;
        logic [31:0] rpc;
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            redir = ($urandom_range(99, 0) < 3);
            rpc   = $urandom();
            rpc   = rpc & 32'hFFFF_FFFC;
            if ($urandom_range(9, 0) == 0) begin
                rpc = 32'hFFFF_FFF0;
            end
            step(redir, rpc, ($urandom_range(9, 0) < 6), ($urandom_range(9, 0) < 7));
        end
        repeat (40) step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (s_if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_drain: got if_valid=%b expected 0", s_if_valid);
        end
    endtask

    initial begin
        bus_hi.imem_req_ready = 1'b1;
        bus_hi.imem_rsp_valid = 1'b0;
        bus_hi.imem_rsp_data  = 32'h0;
        bus_hi.redirect_valid = 1'b0;
        bus_hi.redirect_pc    = 32'h0;
        bus_hi.if_ready       = 1'b0;
        lat_min = 1;
        lat_max = 1;
        test_reset();
        test_reset_pc_wrap();
        test_sequential();
        test_credit_limit();
        test_redirect_flush();
        test_redirect_collision();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
